// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time program loader: ISA word width,
// loader state encoding and error codes.
package cpu_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_COUNT = 2'b01;
  localparam logic [1:0] ERR_PAD   = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  // States in which the loader consumes stream bytes.
  function automatic logic is_busy(input state_e s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles 18-bit words from a byte stream, writes
// them into instruction memory from address 0 and releases the cpu on success.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned INSTR_W   = cpu_pkg::INSTR_W,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    words_loaded
);
  import cpu_pkg::*;

  state_e             r_state;
  state_e             w_next;
  logic [1:0]         w_err_next;

  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_cpu_reset;
  logic [1:0]         r_err_code;

  logic [1:0]         r_byte_idx;
  logic [BYTE_W-1:0]  r_xor;
  logic [15:0]        r_shift;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W:0]    r_words_loaded;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;

  logic               w_accept;
  logic               w_start;
  logic               w_last_byte;
  logic               w_pad_bad;
  logic               w_final_word;
  logic [23:0]        w_word24;
  logic [CNT_W-1:0]   w_count;

  assign w_accept     = r_in_ready & in_valid;
  assign w_start      = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
  assign w_last_byte  = (r_byte_idx == 2'd2);
  assign w_word24     = {in_data, r_shift};
  assign w_pad_bad    = (w_word24 >> INSTR_W) != 24'd0;
  assign w_count      = {in_data, r_count[7:0]};
  assign w_final_word = (CNT_W'(r_words_loaded) + CNT_W'(1)) == r_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and next error code.
  always_comb begin
    w_next     = r_state;
    w_err_next = r_err_code;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_next     = ST_HDR_LO;
          w_err_next = ERR_NONE;
        end
      end
      ST_HDR_LO: if (w_accept) w_next = ST_HDR_HI;
      ST_HDR_HI: begin
        if (w_accept) begin
          if (32'(w_count) > MAX_WORDS) begin
            w_next     = ST_ERROR;
            w_err_next = ERR_COUNT;
          end else if (w_count == CNT_W'(0)) begin
            w_next = ST_CSUM;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_byte) begin
          if (w_pad_bad) begin
            w_next     = ST_ERROR;
            w_err_next = ERR_PAD;
          end else if (w_final_word) begin
            w_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          if (in_data == r_xor) begin
            w_next = ST_DONE;
          end else begin
            w_next     = ST_ERROR;
            w_err_next = ERR_CSUM;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track it cycle-exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_err_code  <= ERR_NONE;
    end else begin
      r_in_ready  <= is_busy(w_next);
      r_busy      <= is_busy(w_next);
      r_done      <= (w_next == ST_DONE);
      r_error     <= (w_next == ST_ERROR);
      r_cpu_reset <= (w_next != ST_DONE);
      r_err_code  <= w_err_next;
    end
  end

  // Byte assembly, checksum accumulation and the one-cycle memory write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx     <= 2'd0;
      r_xor          <= '0;
      r_shift        <= '0;
      r_count        <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (r_mem_we) r_words_loaded <= r_words_loaded + (ADDR_W+1)'(1);
      if (w_start) begin
        r_byte_idx     <= 2'd0;
        r_xor          <= '0;
        r_words_loaded <= '0;
      end else if (w_accept) begin
        r_xor <= r_xor ^ in_data;
        case (r_state)
          ST_HDR_LO: r_count[7:0] <= in_data;
          ST_HDR_HI: r_count      <= w_count;
          ST_DATA: begin
            if (w_last_byte) begin
              r_byte_idx <= 2'd0;
              if (!w_pad_bad) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_words_loaded[ADDR_W-1:0];
                r_mem_wdata <= INSTR_W'(w_word24);
              end
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_shift    <= {in_data, r_shift[15:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign cpu_reset    = r_cpu_reset;
  assign err_code     = r_err_code;
  assign words_loaded = r_words_loaded;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes go into a scoreboard
// queue that a negedge monitor drains; status is checked after each stream.
module tb_prog_loader;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned INSTR_W   = 18;
  localparam int unsigned MAX_WORDS = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic               clk = 1'b0;
  logic               reset, start, in_valid, in_ready, mem_we;
  logic [7:0]         in_data;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_reset, busy, done, error;
  logic [1:0]         err_code;
  logic [ADDR_W:0]    words_loaded;

  wr_t     exp_q[$];
  wr_t     mon_e;
  int      n_vec = 0;
  int      n_err = 0;
  byte_q_t s;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write required", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          n_err++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: byte %0h not accepted, in_ready %b", b, in_ready);
    end
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      @(negedge clk);
    end
  endtask

  task automatic send_stream(input byte_q_t q, input bit gap);
    foreach (q[i]) send_byte(q[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_error"},     32'(error), 32'd0);
    chk({tag, "_err_code"},  32'(err_code), 32'd0);
    chk({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  task automatic chk_done(input string tag, input int words);
    chk({tag, "_done"},      32'(done), 32'd1);
    chk({tag, "_error"},     32'(error), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_words"},     32'(words_loaded), 32'(words));
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_error(input string tag, input logic [1:0] code);
    repeat (2) @(negedge clk);
    chk({tag, "_error"},     32'(error), 32'd1);
    chk({tag, "_err_code"},  32'(err_code), 32'(code));
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset();
    chk_reset_vals("por");

    // Two-word load, back-to-back bytes.
    push_wr(10'd0, 18'h08004);
    push_wr(10'd1, 18'h24000);
    pulse_start();
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    s = '{8'h02, 8'h00, 8'h04, 8'h80, 8'h00, 8'h00, 8'h40, 8'h02};
    send_stream(s, 1'b0);
    chk("s1_cpu_reset_pre_csum", 32'(cpu_reset), 32'd1);
    s = '{8'hC4};
    send_stream(s, 1'b0);
    chk_done("s1", 2);

    // Reload from DONE with in_valid toggling and a start pulse mid-load.
    pulse_start();
    chk("s2_cpu_reset_back", 32'(cpu_reset), 32'd1);
    chk("s2_done_clr", 32'(done), 32'd0);
    push_wr(10'd0, 18'h08004);
    push_wr(10'd1, 18'h24000);
    s = '{8'h02, 8'h00, 8'h04, 8'h80, 8'h00};
    send_stream(s, 1'b1);
    chk("s2_words_mid", 32'(words_loaded), 32'd1);
    pulse_start();
    chk("s2_busy_ignore", 32'(busy), 32'd1);
    chk("s2_words_ignore", 32'(words_loaded), 32'd1);
    s = '{8'h00, 8'h40, 8'h02, 8'hC4};
    send_stream(s, 1'b1);
    chk_done("s2", 2);

    // Empty program.
    pulse_start();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 1'b0);
    chk_done("cnt0", 0);

    // Empty program with a bad checksum.
    pulse_start();
    s = '{8'h00, 8'h00, 8'h01};
    send_stream(s, 1'b0);
    chk_error("csum", 2'b11);

    // Oversized count, started from ERROR.
    pulse_start();
    chk("big_err_clr", 32'(error), 32'd0);
    chk("big_code_clr", 32'(err_code), 32'd0);
    s = '{8'h01, 8'h04};
    send_stream(s, 1'b0);
    chk_error("big", 2'b01);
    chk("big_words", 32'(words_loaded), 32'd0);

    // Nonzero pad bits in the first word.
    pulse_start();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    send_stream(s, 1'b0);
    chk_error("pad", 2'b10);
    chk("pad_words", 32'(words_loaded), 32'd0);

    // Reset in the middle of the second word, then a clean load.
    pulse_start();
    push_wr(10'd0, 18'h08004);
    s = '{8'h02, 8'h00, 8'h04, 8'h80, 8'h00, 8'h00, 8'h40};
    send_stream(s, 1'b0);
    do_reset();
    chk_reset_vals("mid");
    pulse_start();
    push_wr(10'd0, 18'h08004);
    push_wr(10'd1, 18'h24000);
    s = '{8'h02, 8'h00, 8'h04, 8'h80, 8'h00, 8'h00, 8'h40, 8'h02, 8'hC4};
    send_stream(s, 1'b0);
    chk_done("after_rst", 2);

    // Three-word reload from DONE.
    pulse_start();
    chk("s3_cpu_reset_back", 32'(cpu_reset), 32'd1);
    push_wr(10'd0, 18'h3FFFF);
    push_wr(10'd1, 18'h00001);
    push_wr(10'd2, 18'h2AAAA);
    s = '{8'h03, 8'h00, 8'hFF, 8'hFF, 8'h03, 8'h01, 8'h00, 8'h00,
          8'hAA, 8'hAA, 8'h02, 8'h03};
    send_stream(s, 1'b0);
    chk_done("s3", 3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the cpu's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 18-bit instruction words.
- Writes the words sequentially into instruction memory from address 0, then verifies a checksum.
- Holds the cpu in reset until a load completes cleanly; it releases the cpu only then.

Parameters:
- ADDR_W, 10, instruction memory address width.
- INSTR_W, 18, instruction word width (fixed by ISA; ≤24).
- MAX_WORDS, 1024, largest legal word count (≤2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  INSTR_W  write data.
- cpu_reset  out  1  drives the cpu's reset input.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- err_code  out  2  01 count>MAX_WORDS, 10 nonzero pad bits, 11 checksum mismatch.
- words_loaded  out  ADDR_W+1  words written in current/last load.

Behaviour:
- Stream format: COUNT_LO, COUNT_HI (16-bit little-endian), then 3 bytes per word little-endian (word = bits[17:0], bits[23:18] must be 0), then 1 checksum byte = XOR of all preceding bytes, count included.
- Handshake: byte accepted on the rising edge where in_valid && in_ready; in_ready depends only on state (no combinational path from in_valid); in_data ignored when not accepted; in_valid may drop at any time.
- States: IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR.
- IDLE: start -> HDR_LO; clears words_loaded, running XOR, byte index, done, error, err_code.
- HDR_LO -> HDR_HI on accept.
- HDR_HI on accept: count>MAX_WORDS -> ERROR(01); count==0 -> CSUM; else -> DATA.
- DATA: byte index cycles 0,1,2. On 3rd byte accept:
  - If pad bits are nonzero -> ERROR(10), with no write.
  - Otherwise, on the next cycle mem_we=1 for exactly one cycle, with mem_addr=words_loaded (pre-increment) and mem_wdata=word; words_loaded then increments.
  - After the write for the final word -> CSUM.
  - in_ready stays 1 during the write cycle (memory never stalls).
- CSUM on accept: byte==running XOR -> DONE else ERROR(11).
- in_ready=1 only in HDR_LO, HDR_HI, DATA, CSUM. busy=1 in the same states.
- cpu_reset=1 in every state except DONE; it drops on the first cycle in DONE.
- DONE: done=1, cpu_reset=0. start -> HDR_LO, cpu_reset=1 again on the next cycle.
- ERROR: error=1, err_code held, in_ready=0, cpu_reset=1. Stays until start or reset; start -> HDR_LO.
- start while busy: ignored.
- Reset (any state, including mid-word or mid-write) values on the next edge:
  - state IDLE
  - outputs: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, err_code 00, words_loaded 0
  - partial word discarded
- Addresses never wrap: count≤MAX_WORDS guarantees mem_addr≤MAX_WORDS-1.

Decomposition:
- Shared package cpu_pkg: INSTR_W, state encoding, err_code constants (ERR_COUNT, ERR_PAD, ERR_CSUM).
- No sub-module required. The byte-to-word shift register may be split out as word_assembler (3-byte shift, pad check) if it aids reuse.

Test Plan:
- start, stream 02 00 04 80 00 00 40 02 C4:
  - writes mem[0]=08004, mem[1]=24000, each a single mem_we pulse
  - words_loaded=2; done=1; cpu_reset falls after the C4 accept
- Same stream with in_valid toggled every other cycle -> identical writes and result; no byte dropped or duplicated.
- Count 0 stream 00 00 00 -> no mem_we, done=1, words_loaded=0; wrong checksum 01 -> error=1, err_code=11, cpu_reset=1.
- Header 01 04 (count 1025) -> ERROR err_code=01 after HDR_HI accept, no writes. Word bytes 00 00 04 -> ERROR err_code=10, no write.
- Reset asserted after 2nd data byte of word 1 -> all outputs at reset values; a following start plus the full scenario-1 stream loads correctly.
- start pulsed while busy -> ignored. start from DONE -> cpu_reset returns to 1, a reload of 03 00 + 3 words + checksum writes addresses 0..2.
